xor_fold_accum: RTL and testbench

- Streaming, multi-channel XOR fold-and-accumulate block.
- Each beat carries NCH words of IN_W bits. Each word is XOR-folded down to OUT_W bits. The folds are XOR-accumulated across a frame delimited by in_last.
- One registered result per frame is returned through a valid/ready output handshake.
- Parametrised, sequential successor of the fixed 2-channel 32-to-16 combinational XOR fold; used for hash/checksum compression ahead of compare logic.

---
 rtl/xor_fold_accum.sv | 100 ++++++++++
 tb/tb_xor_fold_accum.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/xor_fold_accum.sv
// Streaming multi-channel XOR fold-and-accumulate with one registered result per frame.
// Optional XFOLD_ROT_EN: rotate the accumulator left by one bit before each XOR (order-sensitive).
module xor_fold_accum #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int NCH   = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*IN_W-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*OUT_W-1:0] out_data,
  output logic [CNT_W-1:0]     out_beats
);

  localparam int K = IN_W / OUT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NCH*OUT_W-1:0] acc_q;
  logic [NCH*OUT_W-1:0] fold;
  logic [NCH*OUT_W-1:0] acc_next;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_next;
  logic                 first_q;
  logic                 accept;

  function automatic logic [OUT_W-1:0] fold_word(input logic [IN_W-1:0] w);
    logic [OUT_W-1:0] f;
    f = '0;
    for (int k = 0; k < K; k++) f = f ^ w[k*OUT_W +: OUT_W];
    return f;
  endfunction

  function automatic logic [OUT_W-1:0] acc_step(input logic [OUT_W-1:0] base,
                                                input logic [OUT_W-1:0] f);
`ifdef XFOLD_ROT_EN
    return ((base << 1) | (base >> (OUT_W - 1))) ^ f;
`else
    return base ^ f;
`endif
  endfunction

  // Input stalls while a result is pending and not being drained; clear blocks acceptance.
  assign in_ready = !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fold     = '0;
    acc_next = '0;
    for (int c = 0; c < NCH; c++) begin
      fold[c*OUT_W +: OUT_W]     = fold_word(in_data[c*IN_W +: IN_W]);
      acc_next[c*OUT_W +: OUT_W] = acc_step(first_q ? {OUT_W{1'b0}} : acc_q[c*OUT_W +: OUT_W],
                                            fold[c*OUT_W +: OUT_W]);
    end
  end

  assign cnt_next = first_q ? CNT_W'(1)
                  : (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;

  // Frame state: accumulator, saturating beat counter, first-beat flag.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else if (clear || (accept && in_last)) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else if (accept) begin
      acc_q   <= acc_next;
      cnt_q   <= cnt_next;
      first_q <= 1'b0;
    end
  end

  // Result register: a new last beat on the consume edge reloads without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
    end else if (accept && in_last) begin
      out_valid <= 1'b1;
      out_data  <= acc_next;
      out_beats <= cnt_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xor_fold_accum.sv
// Directed self-checking bench for xor_fold_accum (defaults plus a CNT_W=2 saturation instance).
module tb_xor_fold_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_beats;

  logic        in_ready_s;
  logic        out_valid_s;
  logic [31:0] out_data_s;
  logic [1:0]  out_beats_s;

  int n_checks = 0;
  int n_errors = 0;

  xor_fold_accum dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_beats(out_beats)
  );

  xor_fold_accum #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_beats(out_beats_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  logic [31:0] held_data;

  initial begin
    vecs[0] = '{64'hFFFF0000_12345678, 32'hFFFF_444C};
    vecs[1] = '{64'h00000000_AAAA5555, 32'h0000_FFFF};
    vecs[2] = '{64'hDEADBEEF_FFFFFFFF, 32'h6042_0000};
    vecs[3] = '{64'h80008000_00010002, 32'h0000_0003};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset out_beats", out_beats, 0);
    check("reset in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // Single-beat frames back-to-back at full rate.
    for (int i = 0; i < 4; i++) begin
      drive(vecs[i].data, 1'b1);
      check($sformatf("vec%0d out_valid", i), out_valid, 1);
      check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
      check($sformatf("vec%0d out_beats", i), out_beats, 1);
    end
    tick();
    check("drain out_valid", out_valid, 0);

    // Two-beat frame on ch0.
    drive(64'h00000000_000000FF, 1'b0);
    check("2beat mid out_valid", out_valid, 0);
    drive(64'h00000000_0F000000, 1'b1);
`ifdef XFOLD_ROT_EN
    check("2beat out_data", out_data, 32'h0000_0EFE);
`else
    check("2beat out_data", out_data, 32'h0000_0FFF);
`endif
    check("2beat out_beats", out_beats, 2);
    tick();

    // Backpressure: result held, input stalled, then reload on the consume edge.
    out_ready = 1'b0;
    drive(64'h00000000_AAAA5555, 1'b1);
    check("bp out_valid", out_valid, 1);
    held_data = out_data;
    check("bp out_data", held_data, 32'h0000_FFFF);
    in_valid = 1'b1; in_data = 64'h00000000_00010002; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp%0d in_ready", i), in_ready, 0);
      tick();
      check($sformatf("bp%0d out_valid", i), out_valid, 1);
      check($sformatf("bp%0d out_data stable", i), out_data, 32'h0000_FFFF);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", in_ready, 1);
    tick();
    check("bp reload out_valid", out_valid, 1);
    check("bp reload out_data", out_data, 32'h0000_0003);
    check("bp reload out_beats", out_beats, 1);
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    check("bp drain out_valid", out_valid, 0);

    // Clear mid-frame; the beat offered during clear must be ignored.
    for (int i = 0; i < 3; i++) drive(64'h00000000_AAAA5555, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_data = 64'h00000000_FFFF0000; in_last = 1'b1;
    #1;
    check("clear in_ready", in_ready, 0);
    tick();
    check("clear no accept", out_valid, 0);
    clear = 1'b0;
    drive(64'h00000000_00010002, 1'b1);
    check("after clear out_data", out_data, 32'h0000_0003);
    check("after clear out_beats", out_beats, 1);

    // Clear with a pending result leaves it untouched.
    out_ready = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear keeps out_valid", out_valid, 1);
    check("clear keeps out_data", out_data, 32'h0000_0003);
    out_ready = 1'b1;
    tick();

    // Reset with a result pending.
    drive(64'h00000000_000000FF, 1'b0);
    out_ready = 1'b0;
    drive(64'h00000000_0F000000, 1'b1);
    check("pre-reset out_beats", out_beats, 2);
    rst_n = 1'b0;
    #2;
    check("async rst out_valid", out_valid, 0);
    check("async rst out_data", out_data, 0);
    check("async rst out_beats", out_beats, 0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    drive(64'h00000000_12345678, 1'b1);
    check("post-rst out_beats", out_beats, 1);
    check("post-rst out_data", out_data, 32'h0000_444C);
    tick();

    // Reset mid-frame: next frame restarts from an empty accumulator.
    drive(64'h00000000_AAAA5555, 1'b0);
    drive(64'h00000000_AAAA5555, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(64'h00000000_00010002, 1'b1);
    check("midrst out_data", out_data, 32'h0000_0003);
    check("midrst out_beats", out_beats, 1);
    tick();

    // Six-beat frame: CNT_W=2 instance saturates at 3.
    for (int i = 0; i < 6; i++) drive(64'h00000000_00010000 << i, (i == 5));
`ifdef XFOLD_ROT_EN
    check("sat out_data", out_data, 32'h0000_0000);
    check("sat narrow out_data", out_data_s, 32'h0000_0000);
`else
    check("sat out_data", out_data, 32'h0000_003F);
    check("sat narrow out_data", out_data_s, 32'h0000_003F);
`endif
    check("sat wide out_beats", out_beats, 6);
    check("sat narrow out_beats", out_beats_s, 3);
    check("sat narrow out_valid", out_valid_s, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
